// File: rtl/lcd12864_pkg.sv
// Shared constants, state encoding and helpers for the ST7920 text streamer.
package lcd12864_pkg;

    localparam int LCD_ROWS = 4;
    localparam int LCD_COLS = 16;

    localparam logic [7:0] CMD_FUNC_SET = 8'h30;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;

    // DDRAM start address of each text row; rows 1 and 2 interleave on this controller
    localparam logic [7:0] ROW_ADDR [0:LCD_ROWS-1] = '{8'h80, 8'h90, 8'h88, 8'h98};

    typedef enum logic [2:0] {
        ST_FILL,
        ST_INIT_CMD,
        ST_CLR_WAIT,
        ST_IDLE,
        ST_ROW_CMD,
        ST_ROW_DATA
    } state_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = CMD_FUNC_SET;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_ENTRY;
            default: init_cmd = CMD_CLEAR;
        endcase
    endfunction

    function automatic logic [1:0] first_dirty(input logic [3:0] dirty);
        if (dirty[0])      first_dirty = 2'd0;
        else if (dirty[1]) first_dirty = 2'd1;
        else if (dirty[2]) first_dirty = 2'd2;
        else               first_dirty = 2'd3;
    endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 64x8 character frame buffer: one write port, one registered read port.
module lcd_char_ram (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [5:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [5:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [0:63];
    logic [7:0] r_rdata;

    // NOTE: the array has no reset branch so it maps onto block RAM; the owner fills it after reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd12864_text_streamer.sv
// Streams controller init and dirty text rows from a 4x16 buffer as (rs, byte) pairs.
module lcd12864_text_streamer
    import lcd12864_pkg::*;
#(
    parameter int         INIT_CLEAR_WAIT = 80000,
    parameter logic [7:0] FILL_CHAR       = 8'h20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic [5:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ready,
    input  logic       i_refresh_all,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_out_rs,
    output logic [7:0] o_out_data,
    output logic       o_busy,
    output logic       o_init_done
);

    localparam int                WAIT_W    = (INIT_CLEAR_WAIT > 1) ? $clog2(INIT_CLEAR_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_CLEAR_WAIT - 1);

    state_e            r_state, w_state_nxt;
    logic [5:0]        r_fill_cnt;
    logic [1:0]        r_init_idx;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_init_done;
    logic [3:0]        r_dirty, w_dirty_nxt;
    logic [1:0]        r_row, w_pick_row;
    logic [3:0]        r_col;
    logic [7:0]        r_data_q;
    logic              w_out_valid, w_xfer, w_host_wr, w_wait_done;
    logic              w_ram_we;
    logic [5:0]        w_ram_waddr, w_ram_raddr;
    logic [7:0]        w_ram_wdata, w_ram_rdata;

    assign w_out_valid = (r_state == ST_INIT_CMD) || (r_state == ST_ROW_CMD) || (r_state == ST_ROW_DATA);
    assign w_xfer      = w_out_valid && i_out_ready;
    assign w_host_wr   = i_wr_en && r_init_done;
    assign w_wait_done = (r_wait_cnt == WAIT_LAST);
    assign w_pick_row  = first_dirty(r_dirty);

    lcd_char_ram u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: sequential state uses <= so every process sees pre-edge values within a cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_FILL;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:     if (r_fill_cnt == 6'd63)               w_state_nxt = ST_INIT_CMD;
            ST_INIT_CMD: if (w_xfer && r_init_idx == 2'd3)      w_state_nxt = ST_CLR_WAIT;
            ST_CLR_WAIT: if (w_wait_done)                       w_state_nxt = ST_IDLE;
            ST_IDLE:     if (|r_dirty)                          w_state_nxt = ST_ROW_CMD;
            ST_ROW_CMD:  if (w_xfer)                            w_state_nxt = ST_ROW_DATA;
            ST_ROW_DATA: if (w_xfer && r_col == 4'(LCD_COLS-1)) w_state_nxt = ST_IDLE;
            default:                                            w_state_nxt = ST_FILL;
        endcase
    end

    // Read address runs one column ahead of the byte on the link, so r_data_q refills on each transfer
    always_comb begin
        o_out_valid = w_out_valid;
        o_out_rs    = 1'b0;
        o_out_data  = 8'h00;
        w_ram_we    = w_host_wr;
        w_ram_waddr = i_wr_addr;
        w_ram_wdata = i_wr_data;
        w_ram_raddr = {w_pick_row, 4'd0};
        case (r_state)
            ST_FILL: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_fill_cnt;
                w_ram_wdata = FILL_CHAR;
            end
            ST_INIT_CMD: o_out_data = init_cmd(r_init_idx);
            ST_ROW_CMD: begin
                o_out_data  = ROW_ADDR[r_row];
                w_ram_raddr = {r_row, w_xfer ? 4'd1 : 4'd0};
            end
            ST_ROW_DATA: begin
                o_out_rs    = 1'b1;
                o_out_data  = r_data_q;
                w_ram_raddr = {r_row, 4'(r_col + (w_xfer ? 4'd2 : 4'd1))};
            end
            default: ;
        endcase
        o_busy      = !((r_state == ST_IDLE) && (r_dirty == 4'b0000));
        o_init_done = r_init_done;
        o_wr_ready  = r_init_done;
    end

    // Host set is applied after the row-command clear so a same-cycle write wins
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (r_state == ST_ROW_CMD && w_xfer)      w_dirty_nxt[r_row] = 1'b0;
        if (r_state == ST_CLR_WAIT && w_wait_done) w_dirty_nxt = 4'b1111;
        if (w_host_wr)                            w_dirty_nxt[i_wr_addr[5:4]] = 1'b1;
        if (i_refresh_all && r_init_done)         w_dirty_nxt = w_dirty_nxt | 4'b1111;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill_cnt  <= '0;
            r_init_idx  <= '0;
            r_wait_cnt  <= '0;
            r_init_done <= 1'b0;
            r_dirty     <= 4'b0000;
            r_row       <= '0;
            r_col       <= '0;
            r_data_q    <= '0;
        end else begin
            r_dirty <= w_dirty_nxt;
            case (r_state)
                ST_FILL:     r_fill_cnt <= r_fill_cnt + 6'd1;
                ST_INIT_CMD: if (w_xfer) r_init_idx <= r_init_idx + 2'd1;
                ST_CLR_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    if (w_wait_done) r_init_done <= 1'b1;
                end
                ST_IDLE:     r_row <= w_pick_row;
                ST_ROW_CMD: if (w_xfer) begin
                    r_col    <= 4'd0;
                    r_data_q <= w_ram_rdata;
                end
                ST_ROW_DATA: if (w_xfer) begin
                    r_col    <= r_col + 4'd1;
                    r_data_q <= w_ram_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd12864_text_streamer.sv
// Directed bench for lcd12864_text_streamer with a small cell model and handshake driver.
module tb_lcd12864_text_streamer;

    logic       clk;
    logic       i_rst;
    logic       i_wr_en;
    logic [5:0] i_wr_addr;
    logic [7:0] i_wr_data;
    logic       o_wr_ready;
    logic       i_refresh_all;
    logic       o_out_valid;
    logic       i_out_ready;
    logic       o_out_rs;
    logic [7:0] o_out_data;
    logic       o_busy;
    logic       o_init_done;

    int n_pass;
    int n_checks;
    int n_xfer;

    logic [7:0] model    [64];
    logic [7:0] row_addr [4] = '{8'h80, 8'h90, 8'h88, 8'h98};

    lcd12864_text_streamer #(
        .INIT_CLEAR_WAIT (8),
        .FILL_CHAR       (8'h20)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_wr_ready    (o_wr_ready),
        .i_refresh_all (i_refresh_all),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_rs      (o_out_rs),
        .o_out_data    (o_out_data),
        .o_busy        (o_busy),
        .o_init_done   (o_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one byte after 'stalls' cycles of out_ready=0, checking it holds steady meanwhile.
    task automatic take(input logic exp_rs, input logic [7:0] exp_data, input int stalls,
                        input bit chk_data, input string tag);
        int         n;
        int         s;
        logic [8:0] first;
        n = 0;
        s = stalls;
        @(negedge clk);
        while (!o_out_valid && n < 300) begin
            i_out_ready = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!o_out_valid) begin
            n_checks++;
            $error("FAIL %s: timeout, out_valid never rose", tag);
            return;
        end
        first = {o_out_rs, o_out_data};
        while (s > 0) begin
            i_out_ready = 1'b0;
            @(negedge clk);
            check({23'd0, o_out_valid, o_out_rs, o_out_data}, {23'd0, 1'b1, first}, {tag, "_hold"});
            s--;
        end
        i_out_ready = 1'b1;
        if (chk_data) check({23'd0, o_out_rs, o_out_data}, {23'd0, exp_rs, exp_data}, tag);
        else          check({31'd0, o_out_rs}, {31'd0, exp_rs}, tag);
        n_xfer++;
        @(posedge clk);
        #1 i_out_ready = 1'b0;
    endtask

    function automatic int stall_for(input bit stall_mode);
        return stall_mode ? ((n_xfer * 5 + 1) % 3) : 0;
    endfunction

    task automatic take_cols(input int r, input int c0, input int c1, input bit stall_mode,
                             input bit skip15);
        for (int c = c0; c <= c1; c++) begin
            take(1'b1, model[r*16+c], stall_for(stall_mode), !(skip15 && c == 15),
                 $sformatf("row%0d_col%0d", r, c));
        end
    endtask

    task automatic take_row(input int r, input bit stall_mode);
        take(1'b0, row_addr[r], stall_for(stall_mode), 1'b1, $sformatf("row%0d_cmd", r));
        take_cols(r, 0, 15, stall_mode, 1'b0);
    endtask

    task automatic host_write(input logic [5:0] addr, input logic [7:0] data);
        @(negedge clk);
        i_wr_en   = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        @(posedge clk);
        #1 i_wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        i_refresh_all = 1'b1;
        @(posedge clk);
        #1 i_refresh_all = 1'b0;
    endtask

    task automatic run_init(input bit try_write);
        int gap;
        take(1'b0, 8'h30, 0, 1'b1, "init_30");
        take(1'b0, 8'h0C, 0, 1'b1, "init_0c");
        take(1'b0, 8'h06, 0, 1'b1, "init_06");
        take(1'b0, 8'h01, 0, 1'b1, "init_01");
        @(negedge clk);
        if (try_write) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 6'h05;
            i_wr_data = 8'h59;
        end
        gap = 0;
        while (!o_out_valid && gap < 100) begin
            gap++;
            @(negedge clk);
            i_wr_en = 1'b0;
        end
        check(32'(gap >= 8 && gap < 100), 32'd1, "clr_wait_gap");
        check({31'd0, o_init_done}, 32'd1, "init_done_before_row0");
        check({31'd0, o_wr_ready}, 32'd1, "wr_ready_after_init");
    endtask

    initial begin
        n_pass        = 0;
        n_checks      = 0;
        n_xfer        = 0;
        i_rst         = 1'b1;
        i_wr_en       = 1'b0;
        i_wr_addr     = '0;
        i_wr_data     = '0;
        i_refresh_all = 1'b0;
        i_out_ready   = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 8'h20;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check({31'd0, o_out_valid}, 32'd0, "rst_out_valid");
        check({31'd0, o_out_rs},    32'd0, "rst_out_rs");
        check({24'd0, o_out_data},  32'd0, "rst_out_data");
        check({31'd0, o_init_done}, 32'd0, "rst_init_done");
        check({31'd0, o_wr_ready},  32'd0, "rst_wr_ready");
        check({31'd0, o_busy},      32'd1, "rst_busy");
        i_rst = 1'b0;

        // Write during FILL must be dropped; cell 5 stays blank
        host_write(6'h05, 8'h58);
        run_init(1'b1);
        for (int r = 0; r < 4; r++) take_row(r, 1'b0);
        check(n_xfer, 32'd72, "init_xfer_count");
        @(negedge clk);
        check({31'd0, o_busy}, 32'd0, "busy_after_init_rows");

        host_write(6'h00, 8'h48);
        model[6'h00] = 8'h48;
        host_write(6'h31, 8'h69);
        model[6'h31] = 8'h69;
        take_row(0, 1'b0);
        take_row(3, 1'b0);
        @(negedge clk);
        check({31'd0, o_busy}, 32'd0, "busy_after_hi");

        // Full refresh under a stalling bus driver
        pulse_refresh();
        for (int r = 0; r < 4; r++) take_row(r, 1'b1);
        @(negedge clk);
        check({31'd0, o_busy}, 32'd0, "busy_after_stalled_refresh");

        // Write into row 1 while its column 3 is on the link
        pulse_refresh();
        take_row(0, 1'b0);
        take(1'b0, row_addr[1], 0, 1'b1, "row1_cmd_pass1");
        take_cols(1, 0, 2, 1'b0, 1'b0);
        host_write(6'h1F, 8'h5A);
        model[6'h1F] = 8'h5A;
        take_cols(1, 3, 15, 1'b0, 1'b1);
        take_row(1, 1'b0);
        take_row(2, 1'b0);
        take_row(3, 1'b0);
        @(negedge clk);
        check({31'd0, o_busy}, 32'd0, "dirty_clear_after_resend");

        // Reset in the middle of a row, then the whole sequence again
        pulse_refresh();
        take(1'b0, row_addr[0], 0, 1'b1, "row0_cmd_pre_rst");
        take_cols(0, 0, 4, 1'b0, 1'b0);
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({31'd0, o_out_valid}, 32'd0, "midrow_rst_valid");
        check({31'd0, o_init_done}, 32'd0, "midrow_rst_init_done");
        i_rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 8'h20;
        run_init(1'b0);
        for (int r = 0; r < 4; r++) take_row(r, 1'b0);
        @(negedge clk);
        check({31'd0, o_busy}, 32'd0, "busy_after_restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
